// File: rtl/uart_tx_scheduler.sv
// Byte FIFO that feeds a UART transmitter one byte at a time using its busy handshake.
// Optional WAIT_BUSY watchdog: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int DEPTH          = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clr_overflow,
    input  logic                       uart_busy,
    output logic [DATA_W-1:0]          uart_tx_data,
    output logic                       uart_tx_start,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic                       sched_busy,
    output logic                       timeout_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                start_q, start_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                push, pop, full, empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES-1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        // Strobe is registered: it is high the cycle after LAUNCH.
        start_d   = (state_q == LAUNCH);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        timeout_d = timeout_q;
        to_cnt_d  = to_cnt_q;
        if (state_q == LAUNCH)
            to_cnt_d = '0;
        else if (state_q == WAIT_BUSY)
            to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (!empty && !uart_busy) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_busy)
                    state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!uart_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wptr_d  = wptr_q + PTR_W'(push);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        overflow_d = overflow_q;
        if (wr_en && full)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            start_q    <= start_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= wr_data;
    end

    assign uart_tx_data  = tx_data_q;
    assign uart_tx_start = start_q;
    assign fifo_full     = full;
    assign fifo_empty    = empty;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign sched_busy    = (state_q != IDLE) || !empty;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign timeout_err   = timeout_q;
`else
    // Constant 0; the parameter is still referenced so the disabled build consumes it.
    assign timeout_err   = (TIMEOUT_CYCLES < 1) & 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: accepted bytes are queued at push time, a monitor pops them on each start strobe.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst, wr_en, clr_overflow, ext_busy, uart_busy;
    logic [DW-1:0] wr_data, uart_tx_data;
    logic          uart_tx_start, fifo_full, fifo_empty, overflow, sched_busy, timeout_err;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    uart_tx_scheduler #(.DEPTH(DEPTH), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_overflow(clr_overflow), .uart_busy(uart_busy),
        .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .overflow(overflow), .sched_busy(sched_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int bcnt = 0, busy_len = 5, ignore_starts = 0;
    int n_starts = 0, last_start_cyc = 0, last_push_cyc = 0;
    logic prev_start = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for busy_len cycles after each strobe it accepts
    always @(posedge clk) begin
        if (uart_tx_start) begin
            if (ignore_starts > 0) ignore_starts <= ignore_starts - 1;
            else bcnt <= busy_len;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end
    assign uart_busy = ext_busy | (bcnt != 0);

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (uart_tx_start) begin
            n_starts++;
            last_start_cyc = cyc;
            if (prev_start) chk("start_width", 32'd2, 32'd1);
            else if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("tx_data", 32'(uart_tx_data), 32'(e));
            end
        end
        prev_start = uart_tx_start;
    end

    task automatic push(input logic [DW-1:0] b, input bit accept);
        wr_en = 1'b1; wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge clk); #1;
        wr_en = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string name, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (!sched_busy && exp_q.size() == 0 && !uart_busy) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit seen;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0; ext_busy = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_start", 32'(uart_tx_start), 0);
        chk("rst_data", 32'(uart_tx_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_sched_busy", 32'(sched_busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        @(posedge clk); #1;

        // single byte and its latency
        busy_len = 10; n0 = n_starts;
        push(8'h41, 1);
        wait_drain("single_drain", 100);
        chk("single_latency", 32'(last_start_cyc - last_push_cyc), 2);
        chk("single_starts", 32'(n_starts - n0), 1);
        chk("single_empty", 32'(fifo_empty), 1);
        chk("single_sched_busy", 32'(sched_busy), 0);

        // ordering burst: the first byte is popped while the rest still arrive
        busy_len = 5; n0 = n_starts;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1);
        chk("burst_count", 32'(fifo_count), 7);
        wait_drain("burst_drain", 400);
        chk("burst_starts", 32'(n_starts - n0), 8);

        // overflow with the UART held busy
        ext_busy = 1'b1; n0 = n_starts;
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i), 1);
        push(8'hEE, 0);
        @(negedge clk);
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        @(posedge clk); #1;
        clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_clear", 32'(overflow), 0);
        @(posedge clk); #1;
        clr_overflow = 1'b1; push(8'hEF, 0); clr_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", 32'(overflow), 1);
        chk("ovf_no_start", 32'(n_starts - n0), 0);
        @(posedge clk); #1;
        clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
        ext_busy = 1'b0;
        wait_drain("ovf_drain", 400);
        chk("ovf_starts", 32'(n_starts - n0), 8);

        // start blocked by an external transmitter
        ext_busy = 1'b1; n0 = n_starts;
        push(8'h55, 1);
        idle(10);
        chk("blocked_no_start", 32'(n_starts - n0), 0);
        ext_busy = 1'b0;
        wait_drain("blocked_drain", 100);
        chk("blocked_starts", 32'(n_starts - n0), 1);

        // reset while waiting for the UART to finish
        busy_len = 10; n0 = n_starts;
        push(8'h61, 1); push(8'h62, 1); push(8'h63, 1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bcnt > 0) seen = 1'b1;
        end
        chk("rst_mid_busy_seen", 32'(seen), 1);
        idle(2);
        rst = 1'b1; idle(1); rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_count", 32'(fifo_count), 0);
        chk("rst_mid_start", 32'(uart_tx_start), 0);
        chk("rst_mid_sched_busy", 32'(sched_busy), 0);
        n0 = n_starts;
        idle(30);
        chk("rst_mid_no_pulses", 32'(n_starts - n0), 0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // first strobe is ignored by the UART model, second byte must still go out
        busy_len = 5; ignore_starts = 1;
        push(8'hAA, 1); push(8'hBB, 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        chk("timeout_seen", 32'(seen), 1);
        chk("timeout_delay", 32'(cyc - last_start_cyc), 16);
        wait_drain("timeout_drain", 200);
        chk("timeout_sticky", 32'(timeout_err), 1);
`endif

        // randomized traffic, never exceeding what the FIFO can hold
        n0 = n_starts;
        begin
            int sent = 0;
            for (int i = 0; i < 300; i++) begin
                busy_len = $urandom_range(1, 6);
                if ($urandom_range(0, 2) != 0 && exp_q.size() < DEPTH) begin
                    push(8'($urandom), 1);
                    sent++;
                end else begin
                    idle(1);
                end
            end
            wait_drain("rand_drain", 1000);
            chk("rand_starts", 32'(n_starts - n0), 32'(sent));
        end
        chk("rand_no_ovf", 32'(overflow), 0);
`ifndef UART_TX_SCHED_TIMEOUT_EN
        chk("timeout_tied_low", 32'(timeout_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
